instr_fetch: RTL

- Fetch unit that drives the PC into a combinational 9-bit instruction ROM and consumes its output.
- Registers each returned word into an instruction register, with valid, for the decode stage.
- Owns the PC and handles start, stall, taken branches (with a one-slot flush) and the halt instruction.
- Sits between the instruction ROM and the decoder/execute stage of the 9-bit core.

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 91 +++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, pipeline control and the
// instruction register handed to decode.
interface instr_fetch_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 9
);
   logic               start;
   logic               stall;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    pc_out;
   logic [INSTR_W-1:0] instr_in;
   logic [INSTR_W-1:0] instr_out;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               halted;
   logic [PC_W-1:0]    instr_count;

   modport master (
      input  start, stall, branch_taken, branch_target, instr_in,
      output pc_out, instr_out, instr_pc, instr_valid, halted,
             instr_count
   );

   modport slave (
      output start, stall, branch_taken, branch_target, instr_in,
      input  pc_out, instr_out, instr_pc, instr_valid, halted,
             instr_count
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 9-bit core: owns the PC, registers
// ROM words for decode, handles stall, taken branches and halt.
module instr_fetch #(
   parameter int               PC_W       = 16,
   parameter int               INSTR_W    = 9,
   parameter logic [PC_W-1:0]  START_ADDR = '0,
   parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_t;

   state_t             state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    ir_pc;
   logic               valid;
   logic               halt_q;
   logic [PC_W-1:0]    count;

   assign bus.pc_out      = pc;
   assign bus.instr_out   = ir;
   assign bus.instr_pc    = ir_pc;
   assign bus.instr_valid = valid;
   assign bus.halted      = halt_q;
   assign bus.instr_count = count;

   // Fetch FSM: PC update, instruction register and issue counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         pc     <= START_ADDR;
         ir     <= '0;
         ir_pc  <= '0;
         valid  <= 1'b0;
         halt_q <= 1'b0;
         count  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               valid <= 1'b0;
               if (bus.start) begin
                  state <= RUN;
                  pc    <= START_ADDR;
               end
            end
            RUN: begin
               if (bus.branch_taken) begin
                  // word on instr_in is wrong-path: drop it
                  pc    <= bus.branch_target;
                  valid <= 1'b0;
               end else if (!bus.stall) begin
                  ir    <= bus.instr_in;
                  ir_pc <= pc;
                  valid <= 1'b1;
                  if (count != '1) begin
                     count <= count + 1'b1;
                  end
                  if (bus.instr_in == HALT_INSTR) begin
                     state  <= HALTED;
                     halt_q <= 1'b1;
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            HALTED: begin
               valid <= 1'b0;
               if (bus.start) begin
                  state  <= RUN;
                  pc     <= START_ADDR;
                  halt_q <= 1'b0;
                  count  <= '0;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
